// File: rtl/lieat_lsu_memctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_lsu_memctrl_pkg
//  Description : Shared definitions for the LSU memory controller: FSM state
//                encodings, access-size encodings and request flag layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package lieat_lsu_memctrl_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_FENCE = 3'd3,
      ST_RSP   = 3'd4
   } lsu_state_t;

   // Access size encodings carried in flag[1:0]
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Flag layout: {usign, size[1:0]}
   localparam int FLAG_USIGN_BIT = 2;

   function automatic logic [1:0] flag_size(input logic [2:0] flag);
      return flag[1:0];
   endfunction

   function automatic logic flag_usign(input logic [2:0] flag);
      return flag[FLAG_USIGN_BIT];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lieat_lsu_dataalign.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_lsu_dataalign
//  Description : Combinational lane alignment for the LSU: store byte strobes,
//                store data replication and load data shift plus extension.
//                Misaligned half/word accesses drop the offending address
//                bits instead of faulting. The memory bus is 32 bits wide;
//                XLEN must be at least 32.
//  Revision    : 1.0 - initial release
// ============================================================================
module lieat_lsu_dataalign
   import lieat_lsu_memctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      addr,
   input  logic [2:0]      flag,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata_aligned,
   output logic [XLEN-1:0] rdata_ext
);

   logic [31:0] rshift;
   logic        usign;

   assign usign = flag_usign(flag);

   // Size-dependent strobe, write replication and read shift/extend
   always_comb begin
      wstrb         = 4'b1111;
      wdata_aligned = wdata;
      rshift        = rdata[31:0];
      rdata_ext     = '0;
      case (flag_size(flag))
         SIZE_BYTE: begin
            wstrb         = 4'b0001 << addr;
            wdata_aligned = XLEN'({4{wdata[7:0]}});
            rshift        = rdata[31:0] >> {addr, 3'b000};
            rdata_ext     = usign ? XLEN'(rshift[7:0])
                                  : XLEN'($signed(rshift[7:0]));
         end
         SIZE_HALF: begin
            wstrb         = 4'b0011 << {addr[1], 1'b0};
            wdata_aligned = XLEN'({2{wdata[15:0]}});
            rshift        = rdata[31:0] >> {addr[1], 4'b0000};
            rdata_ext     = usign ? XLEN'(rshift[15:0])
                                  : XLEN'($signed(rshift[15:0]));
         end
         SIZE_WORD: begin
            rdata_ext     = usign ? XLEN'(rshift) : XLEN'($signed(rshift));
         end
         default: begin
            rdata_ext     = usign ? XLEN'(rshift) : XLEN'($signed(rshift));
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lieat_lsu_memctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_lsu_memctrl
//  Description : Single-outstanding LSU memory controller. Accepts a load,
//                store or fence.i request, issues one memory command or an
//                I-cache flush handshake, and returns one response.
//  Revision    : 1.0 - initial release
// ============================================================================
module lieat_lsu_memctrl
   import lieat_lsu_memctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   // request channel
   input  logic            lsu_req_valid,
   output logic            lsu_req_ready,
   input  logic            lsu_req_ren,
   input  logic            lsu_req_wen,
   input  logic            lsu_req_fencei,
   input  logic [XLEN-1:0] lsu_req_addr,
   input  logic [XLEN-1:0] lsu_req_wdata,
   input  logic [2:0]      lsu_req_flag,
   // response channel
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [XLEN-1:0] lsu_rsp_rdata,
   // memory command
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_wdata,
   // memory read return
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   // instruction-cache flush
   output logic            fencei_req,
   input  logic            fencei_ack
);

   lsu_state_t      state;
   lsu_state_t      state_nx;

   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [2:0]      flag_q;
   logic            is_store_q;
   logic [XLEN-1:0] rdata_q;

   logic [3:0]      wstrb_w;
   logic [XLEN-1:0] wdata_al;
   logic [XLEN-1:0] rdata_ext;

   logic            accept;

   assign accept = (state == ST_IDLE) && lsu_req_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; fence.i outranks store, store outranks load
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (lsu_req_valid) begin
               if (lsu_req_fencei)                  state_nx = ST_FENCE;
               else if (lsu_req_wen || lsu_req_ren) state_nx = ST_CMD;
               else                                 state_nx = ST_RSP;
            end
         end
         ST_CMD:   if (mem_ready)     state_nx = is_store_q ? ST_RSP : ST_WAIT;
         ST_WAIT:  if (mem_rvalid)    state_nx = ST_RSP;
         ST_FENCE: if (fencei_ack)    state_nx = ST_RSP;
         ST_RSP:   if (lsu_rsp_ready) state_nx = ST_IDLE;
         default:                     state_nx = ST_IDLE;
      endcase
   end

   // Request capture and load-data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         flag_q     <= '0;
         is_store_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         if (accept) begin
            addr_q     <= lsu_req_addr;
            wdata_q    <= lsu_req_wdata;
            flag_q     <= lsu_req_flag;
            is_store_q <= lsu_req_wen && !lsu_req_fencei;
            // stores, fences and empty requests all answer with zero
            rdata_q    <= '0;
         end
         if ((state == ST_WAIT) && mem_rvalid) begin
            rdata_q <= rdata_ext;
         end
      end
   end

   lieat_lsu_dataalign #(
      .XLEN          (XLEN)
   ) u_dataalign (
      .addr          (addr_q[1:0]),
      .flag          (flag_q),
      .wdata         (wdata_q),
      .rdata         (mem_rdata),
      .wstrb         (wstrb_w),
      .wdata_aligned (wdata_al),
      .rdata_ext     (rdata_ext)
   );

   // Handshake outputs are pure state decode: no input-to-output paths
   assign lsu_req_ready = (state == ST_IDLE);
   assign mem_valid     = (state == ST_CMD);
   assign fencei_req    = (state == ST_FENCE);
   assign lsu_rsp_valid = (state == ST_RSP);
   assign lsu_rsp_rdata = rdata_q;

   // Command fields come straight from the latched request
   assign mem_wen   = is_store_q;
   assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign mem_wstrb = is_store_q ? wstrb_w : 4'b0000;
   assign mem_wdata = wdata_al;

endmodule
`default_nettype wire

// File: doc/lieat_lsu_memctrl.md
LIEAT_LSU_MEMCTRL -- requirements
Module: lieat_lsu_memctrl

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 lsu_req_valid in 1 / lsu_req_ready out 1  request handshake.
REQ-006 lsu_req_ren in 1, lsu_req_wen in 1, lsu_req_fencei in 1  load / store / fence.i request type.
REQ-007 lsu_req_addr in XLEN, lsu_req_wdata in XLEN, lsu_req_flag in 3 ({usign, size[1:0]}).
REQ-008 lsu_rsp_valid out 1 / lsu_rsp_ready in 1 / lsu_rsp_rdata out XLEN  response channel.
REQ-009 mem_valid out 1, mem_ready in 1, mem_wen out 1, mem_addr out XLEN, mem_wstrb out 4, mem_wdata out XLEN  memory command.
REQ-010 mem_rvalid in 1, mem_rdata in XLEN  memory read return.
REQ-011 fencei_req out 1 / fencei_ack in 1  instruction-cache flush handshake.

Function
REQ-012 FSM states SHALL be IDLE, CMD, WAIT, FENCE, RSP; lsu_req_ready = (state == IDLE).
REQ-013 IDLE & lsu_req_valid: latch addr, wdata, flag and type; go to FENCE if fencei, else CMD if ren|wen, else RSP with rdata 0.
REQ-014 Priority when several type bits are set: fencei > wen > ren.
REQ-015 CMD: mem_valid = 1 and command fields held stable until mem_ready; on mem_ready go to RSP for store, WAIT for load.
REQ-016 mem_addr = {latched addr[XLEN-1:2], 2'b00}; mem_wen = store.
REQ-017 Store strobe: size 00 -> 4'b0001 << addr[1:0]; 01 -> 4'b0011 << {addr[1],1'b0}; 10/11 -> 4'b1111.
REQ-018 Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-019 Misaligned half/word accesses SHALL ignore the offending low address bits (half uses addr[1], word uses none); no exception.
REQ-020 WAIT: on mem_rvalid, capture rdata >> (8*addr[1:0]) (half: >> 16*addr[1]), sign-extend (usign = 0) or zero-extend (usign = 1) to XLEN; go to RSP.
REQ-021 Store response rdata SHALL be 0.
REQ-022 FENCE: fencei_req = 1 until fencei_ack; then RSP with rdata 0.
REQ-023 RSP: lsu_rsp_valid = 1 and rdata held until lsu_rsp_ready; on handshake go to IDLE.
REQ-024 A new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-025 Minimum load latency: accept at cycle 0, mem_valid at 1, rsp_valid at 3 with zero-wait memory (mem_ready at 1, mem_rvalid at 2).
REQ-026 mem_rvalid outside WAIT, and fencei_ack outside FENCE, SHALL be ignored.
REQ-027 mem_valid, fencei_req and lsu_rsp_valid SHALL be driven directly from state decode, with no combinational path from any input.

Reset
REQ-028 Reset SHALL force state IDLE and clear all latched registers to 0.
REQ-029 Under reset: lsu_req_ready = 1, lsu_rsp_valid = 0, lsu_rsp_rdata = 0, mem_valid = 0, mem_wen = 0, mem_addr = 0, mem_wstrb = 0, mem_wdata = 0, fencei_req = 0.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately (mem_valid, fencei_req and rsp_valid drop asynchronously); no response is produced.

Structure
REQ-031 FSM state encodings, size encodings (00 byte, 01 half, 10 word) and flag bit positions SHALL live in the shared defines header alongside the INFOBUS field macros.
REQ-032 Alignment and extension logic SHALL be one combinational sub-module, lieat_lsu_dataalign (inputs addr[1:0], flag, wdata, rdata; outputs wstrb, wdata_aligned, rdata_ext).
REQ-033 State registers SHALL use the common general DFF cells.

Verification
REQ-034 Store byte: addr 0x8000_0003, wdata 0x0000_00AB, flag 000 -> mem_wstrb 4'b1000, mem_wdata 0xABAB_ABAB, mem_addr 0x8000_0000, rsp rdata 0.
REQ-035 Load half signed: addr 0x8000_0002, flag 001, mem_rdata 0x8001_1234 -> rdata 0xFFFF_8001; same with flag 101 -> 0x0000_8001.
REQ-036 Back-pressure: mem_ready held low 5 cycles, then lsu_rsp_ready held low 3 cycles -> mem_valid and command fields stable throughout, rsp_valid and rdata stable, lsu_req_ready low until the response handshake.
REQ-037 Fence.i: fencei request, fencei_ack after 4 cycles -> fencei_req high exactly 4 cycles, then one rsp with rdata 0; no mem_valid.
REQ-038 Reset in WAIT: assert reset while awaiting mem_rvalid -> all outputs at reset values immediately; a late mem_rvalid after release produces no response.
REQ-039 Zero-wait load word at 0x8000_0010 -> rsp_valid exactly 3 cycles after the accept edge with rdata = mem_rdata.
